// File: rtl/redirect_ctrl.sv
// Backend redirect controller: selects the oldest branch misprediction report,
// pulses a squash to the backend and holds a redirect request for the frontend.
module redirect_ctrl #(
    parameter int NUM_BRU     = 2,
    parameter int COOL_CYCLES = 3,
    parameter int ROB_IDX_W   = 6,
    parameter int XLEN        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    input  logic                 i_misPred_vld [NUM_BRU],
    input  logic [ROB_IDX_W:0]   i_robIdx      [NUM_BRU],
    input  logic [XLEN-1:0]      i_redirect_pc [NUM_BRU],
    output logic                 o_squash_vld,
    output logic [ROB_IDX_W:0]   o_squash_robIdx,
    output logic                 o_redirect_vld,
    output logic [XLEN-1:0]      o_redirect_pc,
    output logic [ROB_IDX_W:0]   o_redirect_robIdx,
    input  logic                 i_redirect_rdy
);

    localparam int         ROB_W     = ROB_IDX_W + 1;
    localparam logic [3:0] COOL_INIT = 4'(COOL_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_COOL
    } state_e;

    // robIdx is {wrap flag, index}; a differing flag means the ROB pointer has
    // wrapped between the two entries, which inverts the index comparison.
    function automatic logic is_older(input logic [ROB_W-1:0] a,
                                      input logic [ROB_W-1:0] b);
        if (a[ROB_W-1] == b[ROB_W-1]) begin
            return a[ROB_IDX_W-1:0] < b[ROB_IDX_W-1:0];
        end
        return a[ROB_IDX_W-1:0] > b[ROB_IDX_W-1:0];
    endfunction

    state_e            state_q, state_d;
    logic [ROB_W-1:0]  held_rob_q, held_rob_d;
    logic [XLEN-1:0]   held_pc_q, held_pc_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              squash_q, squash_d;
    logic              redirect_vld_q, redirect_vld_d;

    logic              sel_vld;
    logic [ROB_W-1:0]  sel_rob;
    logic [XLEN-1:0]   sel_pc;
    logic              sel_older;

    // Oldest valid report; only a strictly older candidate displaces the
    // current pick, so ties stay with the lowest BRU index.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        sel_vld = 1'b0;
        sel_rob = '0;
        sel_pc  = '0;
        for (int i = 0; i < NUM_BRU; i++) begin
            if (i_misPred_vld[i] && (!sel_vld || is_older(i_robIdx[i], sel_rob))) begin
                sel_vld = 1'b1;
                sel_rob = i_robIdx[i];
                sel_pc  = i_redirect_pc[i];
            end
        end
    end

    assign sel_older = sel_vld && is_older(sel_rob, held_rob_q);

    always_comb begin
        state_d    = state_q;
        held_rob_d = held_rob_q;
        held_pc_d  = held_pc_q;
        cnt_d      = cnt_q;
        squash_d   = 1'b0;

        if (i_flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (sel_vld) begin
                        held_rob_d = sel_rob;
                        held_pc_d  = sel_pc;
                        squash_d   = 1'b1;
                        state_d    = ST_PEND;
                    end
                end
                ST_PEND: begin
                    // An older replacement beats a same-cycle accept: the
                    // frontend must not be sent to the younger target.
                    if (sel_older) begin
                        held_rob_d = sel_rob;
                        held_pc_d  = sel_pc;
                        squash_d   = 1'b1;
                    end else if (i_redirect_rdy) begin
                        cnt_d   = COOL_INIT;
                        state_d = ST_COOL;
                    end
                end
                ST_COOL: begin
                    if (sel_older) begin
                        held_rob_d = sel_rob;
                        held_pc_d  = sel_pc;
                        squash_d   = 1'b1;
                        cnt_d      = '0;
                        state_d    = ST_PEND;
                    end else if (cnt_q <= 4'd1) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign redirect_vld_d = (state_d == ST_PEND);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            held_rob_q     <= '0;
            held_pc_q      <= '0;
            cnt_q          <= '0;
            squash_q       <= 1'b0;
            redirect_vld_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            held_rob_q     <= held_rob_d;
            held_pc_q      <= held_pc_d;
            cnt_q          <= cnt_d;
            squash_q       <= squash_d;
            redirect_vld_q <= redirect_vld_d;
        end
    end

    assign o_squash_vld      = squash_q;
    assign o_squash_robIdx   = held_rob_q;
    assign o_redirect_vld    = redirect_vld_q;
    assign o_redirect_pc     = held_pc_q;
    assign o_redirect_robIdx = held_rob_q;

    a_squash_with_redirect : assert property (
        @(posedge clk) disable iff (!rst) o_squash_vld |-> o_redirect_vld);

endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed bench for redirect_ctrl: a circular-distance age model predicts the
// outputs every cycle, and literal expectations pin the key scenarios.
module tb_redirect_ctrl;

    localparam int NB   = 2;
    localparam int COOL = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        rdy = 1'b0;
    logic        mp_vld [NB];
    logic [6:0]  mp_rob [NB];
    logic [31:0] mp_pc  [NB];
    logic        sq_vld;
    logic [6:0]  sq_rob;
    logic        rd_vld;
    logic [31:0] rd_pc;
    logic [6:0]  rd_rob;

    int total = 0;
    int bad   = 0;

    redirect_ctrl #(.NUM_BRU(NB), .COOL_CYCLES(COOL)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_flush           (flush),
        .i_misPred_vld     (mp_vld),
        .i_robIdx          (mp_rob),
        .i_redirect_pc     (mp_pc),
        .o_squash_vld      (sq_vld),
        .o_squash_robIdx   (sq_rob),
        .o_redirect_vld    (rd_vld),
        .o_redirect_pc     (rd_pc),
        .o_redirect_robIdx (rd_rob),
        .i_redirect_rdy    (rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Age as circular distance on the 7-bit {flg,idx} ring: a is older than b
    // when b lies 1..63 slots ahead of a.
    function automatic bit m_older(input int a, input int b);
        int d;
        d = (b - a + 128) % 128;
        return d >= 1 && d <= 63;
    endfunction

    // Model: an outstanding redirect, a cooldown countdown, and the held branch.
    bit m_pend, m_sq;
    int m_cool, m_rob;
    logic [31:0] m_pc;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend = 0; m_sq = 0; m_cool = 0; m_rob = 0; m_pc = 0;
        end else begin
            int  best_rob;
            logic [31:0] best_pc;
            bit  best_vld;
            best_vld = 0; best_rob = 0; best_pc = 0;
            for (int i = 0; i < NB; i++)
                if (mp_vld[i] && (!best_vld || m_older(int'(mp_rob[i]), best_rob))) begin
                    best_vld = 1; best_rob = int'(mp_rob[i]); best_pc = mp_pc[i];
                end
            m_sq = 0;
            if (flush) begin
                m_pend = 0; m_cool = 0;
            end else if (best_vld && (!(m_pend || m_cool > 0) || m_older(best_rob, m_rob))) begin
                m_rob = best_rob; m_pc = best_pc; m_pend = 1; m_cool = 0; m_sq = 1;
            end else if (m_pend && rdy) begin
                m_pend = 0; m_cool = COOL;
            end else if (m_cool > 0) begin
                m_cool--;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("model_squash_vld", 64'(sq_vld), 64'(m_sq));
            check("model_redirect_vld", 64'(rd_vld), 64'(m_pend));
            if (m_sq) check("model_squash_rob", 64'(sq_rob), 64'(m_rob));
            if (m_pend) begin
                check("model_redirect_rob", 64'(rd_rob), 64'(m_rob));
                check("model_redirect_pc", 64'(rd_pc), 64'(m_pc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        for (int i = 0; i < NB; i++) begin
            mp_vld[i] = 1'b0; mp_rob[i] = '0; mp_pc[i] = '0;
        end
        rdy = 1'b0; flush = 1'b0;
    endtask

    task automatic rep(input int bru, input logic [6:0] rob, input logic [31:0] pc);
        mp_vld[bru] = 1'b1; mp_rob[bru] = rob; mp_pc[bru] = pc;
    endtask

    task automatic expect_out(input string tag, input logic sq, input logic vld,
                              input logic [6:0] rob, input logic [31:0] pc);
        check({tag, "_sq"}, 64'(sq_vld), 64'(sq));
        check({tag, "_vld"}, 64'(rd_vld), 64'(vld));
        if (sq) check({tag, "_sqrob"}, 64'(sq_rob), 64'(rob));
        if (vld) begin
            check({tag, "_rob"}, 64'(rd_rob), 64'(rob));
            check({tag, "_pc"}, 64'(rd_pc), 64'(pc));
        end
    endtask

    task automatic accept_and_idle();
        rdy = 1'b1; step(); rdy = 1'b0;
        check("accept_vld_low", 64'(rd_vld), 64'd0);
        for (int i = 0; i < COOL + 1; i++) step();
    endtask

    initial begin
        idle_in();
        #12;
        check("rst_sq", 64'(sq_vld), 64'd0);
        check("rst_vld", 64'(rd_vld), 64'd0);
        check("rst_sqrob", 64'(sq_rob), 64'd0);
        check("rst_rob", 64'(rd_rob), 64'd0);
        check("rst_pc", 64'(rd_pc), 64'd0);
        @(negedge clk); rst = 1'b1;
        step();

        // Single report, then IDLE timing boundary after accept.
        rep(0, 7'h05, 32'h8000_0100); step(); idle_in();
        expect_out("single", 1, 1, 7'h05, 32'h8000_0100);
        step(); expect_out("single_hold", 0, 1, 7'h05, 32'h8000_0100);
        rdy = 1'b1; step(); rdy = 1'b0;
        expect_out("single_acc", 0, 0, 7'h05, 32'h0);
        step(); step();
        rep(0, 7'h07, 32'h8000_0700); step(); idle_in();
        expect_out("cool_last_drop", 0, 0, 7'h07, 32'h0);
        rep(0, 7'h07, 32'h8000_0700); step(); idle_in();
        expect_out("idle_capture", 1, 1, 7'h07, 32'h8000_0700);
        accept_and_idle();

        // Same-cycle reports: oldest wins, equal robIdx goes to BRU0.
        rep(0, 7'h09, 32'h0000_0900); rep(1, 7'h03, 32'h0000_0300); step(); idle_in();
        expect_out("sel_oldest", 1, 1, 7'h03, 32'h0000_0300);
        accept_and_idle();
        rep(0, 7'h04, 32'h0000_0C00); rep(1, 7'h04, 32'h0000_0D00); step(); idle_in();
        expect_out("sel_tie", 1, 1, 7'h04, 32'h0000_0C00);
        accept_and_idle();

        // Wrap-around age comparison.
        rep(0, 7'h3C, 32'h0000_3C00); step(); idle_in();
        rep(1, 7'h42, 32'h0000_4200); step(); idle_in();
        expect_out("wrap_drop", 0, 1, 7'h3C, 32'h0000_3C00);
        accept_and_idle();
        rep(0, 7'h42, 32'h0000_4200); step(); idle_in();
        rep(1, 7'h3C, 32'h0000_3C01); step(); idle_in();
        expect_out("wrap_replace", 1, 1, 7'h3C, 32'h0000_3C01);
        accept_and_idle();

        // Cooldown filter.
        rep(0, 7'h0A, 32'h0000_0A00); step(); idle_in();
        rdy = 1'b1; step(); rdy = 1'b0;
        rep(1, 7'h0C, 32'h0000_0C00); step(); idle_in();
        expect_out("cool_drop", 0, 0, 7'h0C, 32'h0);
        rep(1, 7'h08, 32'h0000_0800); step(); idle_in();
        expect_out("cool_capture", 1, 1, 7'h08, 32'h0000_0800);
        accept_and_idle();

        // Replacement in the accept cycle.
        rep(0, 7'h14, 32'h0000_1400); step(); idle_in();
        rep(1, 7'h0F, 32'h0000_0F00); rdy = 1'b1; step(); idle_in();
        expect_out("acc_replace", 1, 1, 7'h0F, 32'h0000_0F00);
        step(); expect_out("acc_replace_hold", 0, 1, 7'h0F, 32'h0000_0F00);
        accept_and_idle();

        // Flush with a simultaneous older report.
        rep(0, 7'h1E, 32'h0000_1E00); step(); idle_in();
        flush = 1'b1; rep(1, 7'h01, 32'h0000_0100); step(); idle_in();
        expect_out("flush", 0, 0, 7'h01, 32'h0);
        rep(0, 7'h28, 32'h0000_2800); step(); idle_in();
        expect_out("flush_idle", 1, 1, 7'h28, 32'h0000_2800);

        // Asynchronous reset in the middle of PEND.
        #2 rst = 1'b0;
        #1;
        check("arst_sq", 64'(sq_vld), 64'd0);
        check("arst_vld", 64'(rd_vld), 64'd0);
        check("arst_rob", 64'(rd_rob), 64'd0);
        check("arst_pc", 64'(rd_pc), 64'd0);
        @(negedge clk); rst = 1'b1;
        rdy = 1'b1; step(); rdy = 1'b0;
        step();
        check("arst_no_redirect", 64'(rd_vld), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/redirect_ctrl.md
# redirect_ctrl

Backend redirect controller at the receiving end of the branch-resolution interface. Collects per-cycle misprediction reports (robIdx, corrected target PC) from all branch-capable execution units, selects the oldest by ROB age, broadcasts a one-cycle squash to the backend, and holds a redirect request to the frontend until it is accepted. A cooldown window after acceptance filters stale reports from squashed younger instructions.

## Interface
- NUM_BRU, 2: number of reporting branch units.
- COOL_CYCLES, 3: cooldown length after the frontend accepts a redirect; range 1..15.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- i_flush  in  1  ROB exception/commit flush; overrides everything.
- i_misPred_vld[NUM_BRU]  in  1  misprediction report valid.
- i_robIdx[NUM_BRU]  in  robIdx_t  ROB index of the reporting branch ({flg, idx}).
- i_redirect_pc[NUM_BRU]  in  XLEN  corrected fetch PC.
- o_squash_vld  out  1  one-cycle pulse; squash everything younger than o_squash_robIdx.
- o_squash_robIdx  out  robIdx_t  squash boundary (the branch itself survives).
- o_redirect_vld  out  1  redirect request to frontend.
- o_redirect_pc  out  XLEN  redirect target.
- o_redirect_robIdx  out  robIdx_t  branch that caused the redirect.
- i_redirect_rdy  in  1  frontend accepts redirect.

## Operation
- Age rule: A older than B iff (A.flg == B.flg && A.idx < B.idx) || (A.flg != B.flg && A.idx > B.idx). Equal robIdx: not older.
- Input select (combinational): oldest valid report; ties resolve to lowest BRU index.
- Held entry: robIdx + PC registers, valid in PEND/COOL.
- States: IDLE, PEND, COOL.
  - IDLE: any valid report -> capture selected; squash pulse; -> PEND.
  - PEND: o_redirect_vld=1. Selected report strictly older than held -> replace, squash pulse, stay PEND (a replacement in the accept cycle wins: stay PEND with new entry, no handshake). Else if i_redirect_rdy -> load counter = COOL_CYCLES, -> COOL. Younger/equal reports dropped.
  - COOL: counter decrements each cycle. Selected report strictly older than held -> capture, squash pulse, -> PEND. Younger/equal dropped. Counter reaching 0 -> IDLE (transition on the cycle counter is 1).
- i_flush: -> IDLE, held invalid, counter 0, no squash pulse, any same-cycle reports ignored.
- Counter width 4 bits; no wrap (clamped at 0).

## Timing
- Reset values: o_squash_vld=0, o_redirect_vld=0, o_squash_robIdx=0, o_redirect_robIdx=0, o_redirect_pc=0; state IDLE; counter 0.
- Latency: report valid in cycle N -> o_squash_vld and o_redirect_vld high in cycle N+1 (all outputs registered).
- o_squash_vld high exactly one cycle per capture/replacement; o_squash_robIdx equals o_redirect_robIdx in that cycle.
- Redirect handshake: vld stays high with stable pc/robIdx until vld&rdy, except on older replacement (pc/robIdx change, vld stays high). rdy without vld ignored.
- Handshake in cycle M -> o_redirect_vld low in M+1; COOL spans M+1..M+COOL_CYCLES; IDLE at M+COOL_CYCLES+1.
- Async reset mid-PEND: outputs drop immediately on rst assertion; no redirect is delivered.

## Test plan
- Single report: BRU0 robIdx {0,5}, pc 0x8000_0100 at cycle 1 -> cycle 2 squash pulse {0,5}, redirect vld pc 0x8000_0100; rdy at cycle 4 -> vld low cycle 5, IDLE cycle 8 (COOL_CYCLES=3).
- Same-cycle reports: BRU0 {0,9}, BRU1 {0,3} -> redirect/squash robIdx {0,3} with BRU1 pc; equal robIdx on both -> BRU0 pc.
- Wrap-around age: held {0,60}, new {1,2} dropped; held {1,2}, new {0,60} replaces, second squash pulse, pc updated, vld continuous.
- Cooldown filter: after accept of {0,10}, report {0,12} in COOL dropped (no pulse); report {0,8} in COOL -> squash pulse, PEND with {0,8}.
- Replacement in accept cycle: rdy=1 same cycle as older report -> stays PEND with new entry, next accept needed.
- Flush: i_flush during PEND with simultaneous report -> next cycle vld=0, no squash pulse, IDLE; async rst low mid-PEND -> all outputs 0 immediately.
